// File: rtl/mux4_rr_scheduler.sv
`default_nettype none
// ============================================================================
// mux4_rr_scheduler : round-robin scheduler in front of a shared 4:1 1-bit mux
// Rev 1.0
// ============================================================================

module mux4_1b (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       z
);
  assign z = d[s];
endmodule

module mux4_rr_scheduler #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       z
);
  localparam int c_cnt_w = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sel;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [3:0]           r_gnt;

  logic                 w_any;
  logic [1:0]           w_win;
  logic                 w_end;
  logic                 w_mux_z;

  // Scan from lowest to highest priority so the nearest requester after sel wins.
  always_comb begin
    w_win = r_sel;
    w_any = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (req[r_sel + 2'(k)]) begin
        w_win = r_sel + 2'(k);
        w_any = 1'b1;
      end
    end
  end

  assign w_end = (r_cnt == '0) || !req[r_sel];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'd3;
      r_cnt   <= '0;
      r_gnt   <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_sel   <= w_win;
            r_gnt   <= 4'b0001 << w_win;
            r_cnt   <= c_cnt_load;
          end
        end
        ST_GRANT: begin
          if (w_end) begin
            if (w_any) begin
              r_sel <= w_win;
              r_gnt <= 4'b0001 << w_win;
              r_cnt <= c_cnt_load;
            end else begin
              // sel keeps the last grantee so rotation resumes where it left off
              r_state <= ST_IDLE;
              r_gnt   <= 4'b0000;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mux4_1b u_mux (
    .d (d),
    .s (r_sel),
    .z (w_mux_z)
  );

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = (r_state == ST_GRANT);
  assign z     = valid & w_mux_z;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mux4_rr_scheduler : directed and randomized checks of HOLD=4 and HOLD=1
// Rev 1.0
// ============================================================================
module tb_mux4_rr_scheduler;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt4, gnt1;
  logic [1:0] sel4, sel1;
  logic       valid4, valid1, z4, z1;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per instance, busy flag, current grantee and cycles used.
  int hold [2];
  int m_busy [2];
  int m_sel [2];
  int m_used [2];

  always #5 clk = ~clk;

  mux4_rr_scheduler #(.HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt4), .sel(sel4), .valid(valid4), .z(z4)
  );

  mux4_rr_scheduler #(.HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt1), .sel(sel1), .valid(valid1), .z(z1)
  );

  function automatic int pick(int last, logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt(int i);
    return (m_busy[i] != 0) ? (4'b0001 << m_sel[i]) : 4'b0000;
  endfunction

  function automatic logic exp_z(int i);
    return (m_busy[i] != 0) ? d[m_sel[i]] : 1'b0;
  endfunction

  task automatic model_step();
    int w;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i] = 0; m_sel[i] = 3; m_used[i] = 0;
      end else if (m_busy[i] == 0) begin
        w = pick(m_sel[i], req);
        if (w >= 0) begin m_busy[i] = 1; m_sel[i] = w; m_used[i] = 1; end
      end else if (!req[m_sel[i]] || m_used[i] == hold[i]) begin
        w = pick(m_sel[i], req);
        if (w >= 0) begin m_sel[i] = w; m_used[i] = 1; end
        else m_busy[i] = 0;
      end else begin
        m_used[i] = m_used[i] + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 4'b0000; d = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; d = 4'b1111;
    tick(); tick();
    n_vec++;
    if ({gnt4, sel4, valid4, z4} !== {4'b0000, 2'd3, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got gnt=%b sel=%0d valid=%b z=%b, want 0000/3/0/0", gnt4, sel4, valid4, z4);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (gnt4 !== 4'b0001 || gnt1 !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_first_grant: got gnt4=%b gnt1=%b, want 0001", gnt4, gnt1);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010; d = 4'b0010;
    tick();
    n_vec++;
    if ({gnt4, sel4, valid4, z4} !== {4'b0010, 2'd1, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL single_grant: got gnt=%b sel=%0d valid=%b z=%b, want 0010/1/1/1", gnt4, sel4, valid4, z4);
    end
    for (int c = 0; c < 9; c++) begin
      tick();
      d = d ^ 4'b0010;
      #1;
      n_vec++;
      if (gnt4 !== 4'b0010 || valid4 !== 1'b1 || z4 !== d[1]) begin
        n_err++;
        $display("FAIL single_hold_cycle%0d: got gnt=%b valid=%b z=%b, want 0010/1/%b", c, gnt4, valid4, z4, d[1]);
      end
    end
  endtask

  task automatic test_full_load();
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        n_vec++;
        if (gnt4 !== (4'b0001 << (g % 4)) || sel4 !== 2'(g % 4) || valid4 !== 1'b1) begin
          n_err++;
          $display("FAIL full_load g%0d c%0d: got gnt=%b sel=%0d valid=%b, want grantee %0d", g, c, gnt4, sel4, valid4, g % 4);
        end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0101;
    tick(); tick();
    req = 4'b0100;
    tick();
    n_vec++;
    if (gnt4 !== 4'b0100 || sel4 !== 2'd2 || valid4 !== 1'b1) begin
      n_err++;
      $display("FAIL early_release: got gnt=%b sel=%0d valid=%b, want 0100/2/1", gnt4, sel4, valid4);
    end
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (gnt4 !== 4'b0100) begin
        n_err++;
        $display("FAIL early_release_hold c%0d: got gnt=%b, want 0100", c, gnt4);
      end
    end
    tick();
    n_vec++;
    if (gnt4 !== 4'b0001) begin
      n_err++;
      $display("FAIL early_release_next: got gnt=%b, want 0001", gnt4);
    end
  endtask

  task automatic test_idle_priority();
    do_reset();
    req = 4'b0100; d = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    n_vec++;
    if ({gnt4, sel4, valid4, z4} !== {4'b0000, 2'd2, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL idle_return: got gnt=%b sel=%0d valid=%b z=%b, want 0000/2/0/0", gnt4, sel4, valid4, z4);
    end
    req = 4'b1010;
    tick();
    n_vec++;
    if (gnt4 !== 4'b1000 || sel4 !== 2'd3) begin
      n_err++;
      $display("FAIL priority_memory: got gnt=%b sel=%0d, want 1000/3", gnt4, sel4);
    end
  endtask

  task automatic test_reset_mid_hold1();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    n_vec++;
    if (gnt4 !== 4'b0000 || sel4 !== 2'd3 || valid4 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_grant: got gnt=%b sel=%0d valid=%b, want 0000/3/0", gnt4, sel4, valid4);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (gnt1 !== seq[c] || valid1 !== 1'b1) begin
        n_err++;
        $display("FAIL hold1_rotate c%0d: got gnt=%b valid=%b, want %b/1", c, gnt1, valid1, seq[c]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 3))
        0:       req = 4'b0000;
        1:       req = 4'b1111;
        default: req = 4'($urandom);
      endcase
      d = 4'($urandom);
      tick();
      n_vec++;
      if ({gnt4, sel4, valid4, z4} !== {exp_gnt(0), 2'(m_sel[0]), m_busy[0] != 0, exp_z(0)}) begin
        n_err++;
        $display("FAIL random_hold4 c%0d: got gnt=%b sel=%0d valid=%b z=%b, want %b/%0d/%0d/%b",
                 c, gnt4, sel4, valid4, z4, exp_gnt(0), m_sel[0], m_busy[0], exp_z(0));
      end
      n_vec++;
      if ({gnt1, sel1, valid1, z1} !== {exp_gnt(1), 2'(m_sel[1]), m_busy[1] != 0, exp_z(1)}) begin
        n_err++;
        $display("FAIL random_hold1 c%0d: got gnt=%b sel=%0d valid=%b z=%b, want %b/%0d/%0d/%b",
                 c, gnt1, sel1, valid1, z1, exp_gnt(1), m_sel[1], m_busy[1], exp_z(1));
      end
    end
  endtask

  initial begin
    hold[0] = 4; hold[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_sel[i] = 3; m_used[i] = 0;
    end
    rst_n = 1'b0; req = 4'b0000; d = 4'b0000;
    #2;
    test_reset();
    test_single();
    test_full_load();
    test_early_release();
    test_idle_priority();
    test_reset_mid_hold1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
